// File: rtl/riscv_data_mem_ctrl.sv
// riscv_data_mem_ctrl
//   Byte-addressable data/instruction RAM controller for the multicycle RV32 core's memory port.
//   Stores are committed on the request edge. Loads are registered, so read_data is valid one
//   cycle after the request. Byte-lane enables, size/alignment/range checks and sticky error
//   flags are handled here.
//
// Build option:
//   DMEM_CYCLE_CSR_EN  adds a read-only free-running 32-bit cycle counter mapped at
//                      byte address BASE_ADDR + 4*DEPTH_WORDS.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit RAM words (power of 2, >= 2)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   INIT_FILE    preload image name; no preload is performed by this implementation
//
// Ports:
//   clk              core clock, rising edge
//   rst              synchronous active-high reset (RAM contents are not cleared)
//   mem_en           request strobe
//   mem_read         load/fetch request
//   mem_write        store request
//   mem_data_length  00 byte, 01 half, 10 word, 11 reserved
//   adr              byte address
//   write_data       right-aligned store data
//   read_data        right-aligned, zero-extended load data (held until the next read)
//   rd_valid         one-cycle pulse when read_data was updated
//   misalign_err     sticky misalignment flag
//   access_err       sticky range / reserved-length / read+write conflict flag

module riscv_data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_data_length,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        rd_valid,
    output logic        misalign_err,
    output logic        access_err
);

    localparam int unsigned AddrW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) << 2;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b10;
    localparam logic [1:0] LenRsvd = 2'b11;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Address decode and request classification
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             above_base;
    logic             in_ram;
    logic             csr_hit;
    logic [AddrW-1:0] word_idx;

    assign offset     = adr - BASE_ADDR;
    assign above_base = (adr >= BASE_ADDR);
    assign in_ram     = above_base & ({1'b0, offset} < MemBytes);
    assign word_idx   = offset[AddrW+1:2];

    logic req;
    logic unaligned;
    logic bad_access;
    logic mis_set;
    logic acc_set;
    logic do_write;
    logic do_read;

    always_comb begin
        req       = mem_en & (mem_read | mem_write);
        unaligned = ((mem_data_length == LenHalf) & adr[0])
                  | ((mem_data_length == LenWord) & (|adr[1:0]));
        // The CSR word is read-only, so a write there counts as an access fault.
        bad_access = (mem_read & mem_write)
                   | (mem_data_length == LenRsvd)
                   | ~(in_ram | csr_hit)
                   | (csr_hit & mem_write);
        mis_set  = req & unaligned;
        acc_set  = req & bad_access;
        do_write = req & ~unaligned & ~bad_access & mem_write & in_ram & ~rst;
        do_read  = req & ~unaligned & ~bad_access & mem_read;
    end

    // ------------------------------------------------------------------
    // Store path: replicate the right-aligned data across lanes, then mask
    // ------------------------------------------------------------------
    logic [3:0]  wr_be;
    logic [31:0] wr_word;

    always_comb begin
        wr_be   = 4'b0000;
        wr_word = write_data;
        case (mem_data_length)
            LenByte: begin
                wr_be   = 4'b0001 << adr[1:0];
                wr_word = {4{write_data[7:0]}};
            end
            LenHalf: begin
                wr_be   = adr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{write_data[15:0]}};
            end
            LenWord: begin
                wr_be   = 4'b1111;
            end
            default: begin
                wr_be   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read source: RAM word, or the cycle counter when it is mapped
    // ------------------------------------------------------------------
    logic [31:0] src_word;

`ifdef DMEM_CYCLE_CSR_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign csr_hit  = above_base & ({1'b0, offset} >= MemBytes)
                    & ({1'b0, offset} < (MemBytes + 33'd4));
    // Counter value present during the request cycle is what gets returned.
    assign src_word = csr_hit ? cycle_q : mem[word_idx];
`else
    assign csr_hit  = 1'b0;
    assign src_word = mem[word_idx];
`endif

    // ------------------------------------------------------------------
    // Lane extraction and zero extension
    // ------------------------------------------------------------------
    logic [31:0] shifted;
    logic [31:0] rd_extract;

    always_comb begin
        shifted    = src_word >> {adr[1:0], 3'b000};
        rd_extract = shifted;
        case (mem_data_length)
            LenByte: rd_extract = {24'h0, shifted[7:0]};
            LenHalf: rd_extract = {16'h0, shifted[15:0]};
            default: rd_extract = shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and sticky error registers
    // ------------------------------------------------------------------
    logic [31:0] read_data_q;
    logic        rd_valid_q;
    logic        misalign_q;
    logic        access_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            access_q    <= 1'b0;
        end else begin
            // Illegal reads (including read+write conflicts) still answer, with zero data.
            rd_valid_q <= mem_en & mem_read;
            if (mem_en & mem_read) begin
                read_data_q <= do_read ? rd_extract : 32'h0;
            end
            misalign_q <= misalign_q | mis_set;
            access_q   <= access_q | acc_set;
        end
    end

    assign read_data    = read_data_q;
    assign rd_valid     = rd_valid_q;
    assign misalign_err = misalign_q;
    assign access_err   = access_q;

endmodule
